// File: rtl/instruction_encoder.sv
// Two-stage streaming encoder: packs decoded RV64 field records into 32-bit instruction words.
// Stage 1 holds the fields plus the range/format verdict; stage 2 holds the packed word.
module instruction_encoder #(
  parameter int IMMEDIATE_WIDTH = 32,
  parameter int TYPE_WIDTH      = 3,
  parameter int REGISTER_WIDTH  = 5,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TYPE_WIDTH-1:0]      in_type,
  input  logic [6:0]                 in_opcode,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [REGISTER_WIDTH-1:0]  in_rd,
  input  logic [REGISTER_WIDTH-1:0]  in_rs1,
  input  logic [REGISTER_WIDTH-1:0]  in_rs2,
  input  logic [IMMEDIATE_WIDTH-1:0] in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic                       out_error,
  output logic [COUNT_WIDTH-1:0]     enc_count,
  output logic [COUNT_WIDTH-1:0]     err_count
);

  localparam logic [TYPE_WIDTH-1:0] TYPE_R  = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] TYPE_I  = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] TYPE_S  = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] TYPE_SB = TYPE_WIDTH'(3);
  localparam logic [TYPE_WIDTH-1:0] TYPE_U  = TYPE_WIDTH'(4);
  localparam logic [TYPE_WIDTH-1:0] TYPE_UJ = TYPE_WIDTH'(5);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_SB,
    FMT_U,
    FMT_UJ,
    FMT_BAD
  } fmt_e;

  fmt_e                       in_fmt;
  logic                       in_err;

  logic                       s1_valid;
  fmt_e                       s1_fmt;
  logic                       s1_err;
  logic [6:0]                 s1_opcode;
  logic [2:0]                 s1_funct3;
  logic [6:0]                 s1_funct7;
  logic [REGISTER_WIDTH-1:0]  s1_rd;
  logic [REGISTER_WIDTH-1:0]  s1_rs1;
  logic [REGISTER_WIDTH-1:0]  s1_rs2;
  logic [IMMEDIATE_WIDTH-1:0] s1_imm;

  logic [31:0]                packed_inst;
  logic                       s2_load;
  logic                       out_fire;

  // A field is in range when every bit above the encodable width matches the sign bit.
  function automatic logic all_equal(input logic [IMMEDIATE_WIDTH-1:0] value, input int lsb);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < IMMEDIATE_WIDTH; i++) begin
      if (i >= lsb) begin
        ones  = ones & value[i];
        zeros = zeros & ~value[i];
      end
    end
    return ones | zeros;
  endfunction

  always_comb begin
    in_fmt = FMT_BAD;
    in_err = 1'b1;
    case (in_type)
      TYPE_R: begin
        in_fmt = FMT_R;
        in_err = 1'b0;
      end
      TYPE_I: begin
        in_fmt = FMT_I;
        in_err = !all_equal(in_imm, 11);
      end
      TYPE_S: begin
        in_fmt = FMT_S;
        in_err = !all_equal(in_imm, 11);
      end
      TYPE_SB: begin
        in_fmt = FMT_SB;
        in_err = !all_equal(in_imm, 12) || in_imm[0];
      end
      TYPE_U: begin
        in_fmt = FMT_U;
        in_err = (in_imm[11:0] != 12'h000);
      end
      TYPE_UJ: begin
        in_fmt = FMT_UJ;
        in_err = !all_equal(in_imm, 20) || in_imm[0];
      end
      default: begin
        in_fmt = FMT_BAD;
        in_err = 1'b1;
      end
    endcase
  end

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= FMT_BAD;
      s1_err    <= 1'b0;
      s1_opcode <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_imm    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt    <= in_fmt;
        s1_err    <= in_err;
        s1_opcode <= in_opcode;
        s1_funct3 <= in_funct3;
        s1_funct7 <= in_funct7;
        s1_rd     <= in_rd;
        s1_rs1    <= in_rs1;
        s1_rs2    <= in_rs2;
        s1_imm    <= in_imm;
      end
    end
  end

  always_comb begin
    packed_inst = NOP_INST;
    case (s1_fmt)
      FMT_R:
        packed_inst = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I:
        packed_inst = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S:
        packed_inst = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_SB:
        packed_inst = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                       s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U:
        packed_inst = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_UJ:
        packed_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
      default:
        packed_inst = NOP_INST;
    endcase
    if (s1_err) packed_inst = NOP_INST;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_error <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_inst  <= packed_inst;
        out_error <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_fire) begin
      if (!out_error && (enc_count != '1)) enc_count <= enc_count + 1'b1;
      if (out_error && (err_count != '1))  err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vector table, hand-built backpressure/reset
// sequences, and random traffic scored against an arithmetic reference model.
module tb_instruction_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_error;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  instruction_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_error (out_error),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  int tests;
  int fails;

  logic [32:0] exp_q[$];
  logic [15:0] enc_m;
  logic [15:0] err_m;
  logic        hold;
  logic [31:0] prev_inst;
  logic        prev_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: spec rules expressed as signed ranges and shift/mask arithmetic.
  function automatic logic [32:0] model_enc(input logic [31:0] t, op, f3, f7, rd, rs1, rs2, imm);
    longint      s;
    logic [31:0] w;
    logic        e;
    s = longint'($signed(imm));
    e = 1'b0;
    w = 32'h0;
    case (t)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: begin
        e = (s < -2048) || (s > 2047);
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      2: begin
        e = (s < -2048) || (s > 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 32'h1F) << 7) | op;
      end
      3: begin
        e = (s < -4096) || (s > 4095) || ((imm % 2) != 0);
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
          | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op;
      end
      4: begin
        e = (imm % 4096) != 0;
        w = (imm & 32'hFFFFF000) | (rd << 7) | op;
      end
      5: begin
        e = (s < -1048576) || (s > 1048575) || ((imm % 2) != 0);
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
    return {e, w};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      enc_m = 16'h0;
      err_m = 16'h0;
      hold  = 1'b0;
    end else begin
      check("enc_count", 64'(enc_count), 64'(enc_m));
      check("err_count", 64'(err_count), 64'(err_m));
      if (hold)
        check("hold_stable", {31'h0, out_valid, out_error, out_inst}, {31'h0, 1'b1, prev_err, prev_inst});
      if (in_valid && in_ready)
        exp_q.push_back(model_enc(32'(in_type), 32'(in_opcode), 32'(in_funct3), 32'(in_funct7),
                                  32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none", out_inst);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("sb_inst", 64'(out_inst), 64'(e[31:0]));
          check("sb_error", 64'(out_error), 64'(e[32]));
          if (out_error) begin
            if (err_m != 16'hFFFF) err_m = err_m + 16'h1;
          end else begin
            if (enc_m != 16'hFFFF) enc_m = enc_m + 16'h1;
          end
        end
      end
      hold      = out_valid && !out_ready;
      prev_inst = out_inst;
      prev_err  = out_error;
    end
  end

  function automatic vec_t mkv(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, rs1, rs2,
                               input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    vec_t v;
    v.t = t; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive_fields(input vec_t v);
    in_type = v.t; in_opcode = v.op; in_funct3 = v.f3; in_funct7 = v.f7;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the record.
  task automatic send(input vec_t v);
    int  n;
    logic ok;
    drive_fields(v);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  vec_t        vecs[16];
  vec_t        rv;
  int          n_ok;
  int          n_err;
  int          n;
  logic [31:0] got[$];
  logic        accepted;
  logic [31:0] bnd[12];
  vec_t        add_v;
  vec_t        sub_v;
  vec_t        lui_v;

  initial begin
    tests = 0; fails = 0;
    enc_m = 0; err_m = 0; hold = 0; prev_inst = 0; prev_err = 0;
    in_valid = 0; out_ready = 1;
    in_type = 0; in_opcode = 0; in_funct3 = 0; in_funct7 = 0;
    in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;

    vecs[0]  = mkv(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2,  32'h0,        32'h002081B3, 1'b0);
    vecs[1]  = mkv(3'd1, 7'h13, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd31, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    vecs[2]  = mkv(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,  32'h00000800, 32'h00000013, 1'b1);
    vecs[3]  = mkv(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2,  32'h00000008, 32'h00208463, 1'b0);
    vecs[4]  = mkv(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2,  32'h00000007, 32'h00000013, 1'b1);
    vecs[5]  = mkv(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,  32'h00000800, 32'h001000EF, 1'b0);
    vecs[6]  = mkv(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0,  32'h12345000, 32'h123452B7, 1'b0);
    vecs[7]  = mkv(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0,  32'h12345001, 32'h00000013, 1'b1);
    vecs[8]  = mkv(3'd2, 7'h23, 3'd2, 7'h00, 5'd9, 5'd1, 5'd2,  32'hFFFFFFFC, 32'hFE20AE23, 1'b0);
    vecs[9]  = mkv(3'd7, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2,  32'h0,        32'h00000013, 1'b1);
    vecs[10] = mkv(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,  32'hFFFFF800, 32'h80000093, 1'b0);
    vecs[11] = mkv(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,  32'hFFFFF000, 32'h80000063, 1'b0);
    vecs[12] = mkv(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,  32'h00001000, 32'h00000013, 1'b1);
    vecs[13] = mkv(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,  32'h00100000, 32'h00000013, 1'b1);
    vecs[14] = mkv(3'd0, 7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7,  32'h0,        32'h407302B3, 1'b0);
    vecs[15] = mkv(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,  32'h000007FF, 32'h7FF00093, 1'b0);
    add_v = vecs[0];
    sub_v = vecs[14];
    lui_v = vecs[6];
    bnd = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4095, 32'd4094,
            32'hFFFFF000, 32'hFFFFEFFF, 32'd1048574, 32'd1048576, 32'hFFF00000, 32'h12345000};

    // reset values
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_inst",  64'(out_inst),  64'(0));
    check("rst_out_error", 64'(out_error), 64'(0));
    check("rst_enc_count", 64'(enc_count), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // directed table
    n_ok = 0; n_err = 0;
    for (int i = 0; i < 16; i++) begin
      send(vecs[i]);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 6);
      check($sformatf("vec%0d_latency", i), 64'(n), 64'(2));
      check($sformatf("vec%0d_inst", i), 64'(out_inst), 64'(vecs[i].exp_inst));
      check($sformatf("vec%0d_error", i), 64'(out_error), 64'(vecs[i].exp_err));
      if (vecs[i].exp_err) n_err++; else n_ok++;
      @(posedge clk);
      #1;
    end
    check("table_enc_count", 64'(enc_count), 64'(n_ok));
    check("table_err_count", 64'(err_count), 64'(n_err));

    // backpressure: two records fill the pipe, the third stalls
    out_ready = 1'b0;
    drive_fields(add_v); in_valid = 1'b1;
    @(negedge clk); check("bp_ready0", 64'(in_ready), 64'(1));
    @(posedge clk); #1 drive_fields(sub_v);
    @(negedge clk); check("bp_ready1", 64'(in_ready), 64'(1));
    @(posedge clk); #1 drive_fields(lui_v);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready_stall", 64'(in_ready), 64'(0));
      check("bp_hold_inst", {31'h0, out_valid, out_inst}, {31'h0, 1'b1, 32'h002081B3});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_inst);
      accepted = in_valid && in_ready;
      @(posedge clk);
      #1 if (accepted) in_valid = 1'b0;
    end
    check("bp_delivered", 64'(got.size()), 64'(3));
    if (got.size() == 3) begin
      check("bp_order0", 64'(got[0]), 64'(32'h002081B3));
      check("bp_order1", 64'(got[1]), 64'(32'h407302B3));
      check("bp_order2", 64'(got[2]), 64'(32'h123452B7));
    end

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rv.t = 3'($urandom_range(0, 7));
      rv.op = 7'($urandom); rv.f3 = 3'($urandom); rv.f7 = 7'($urandom);
      rv.rd = 5'($urandom); rv.rs1 = 5'($urandom); rv.rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
        0: rv.imm = $urandom;
        1: rv.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
        2: rv.imm = bnd[$urandom_range(0, 11)];
        default: rv.imm = $urandom & 32'hFFFFF000;
      endcase
      drive_fields(rv);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1 check("rand_drain", 64'(exp_q.size()), 64'(0));

    // saturation of enc_count
    drive_fields(add_v);
    in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("sat_enc_count", 64'(enc_count), 64'(16'hFFFF));

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    send(add_v);
    send(sub_v);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out_inst",  64'(out_inst),  64'(0));
    check("mid_rst_enc_count", 64'(enc_count), 64'(0));
    check("mid_rst_err_count", 64'(err_count), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(out_valid), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Streaming RV64 instruction encoder: the inverse of the decode path.
- Accepts decoded fields (format, opcode, funct3, funct7, rd, rs1, rs2, imm) on a valid/ready interface and packs them into a 32-bit instruction word.
- Two-stage pipeline with full throughput, backpressure and immediate range checking.
- Used by the self-check bench and the trap/patch path to generate instruction words from field records.

Parameters:
- IMMEDIATE_WIDTH, 32, width of the imm input.
- TYPE_WIDTH, 3, width of the format code; codes come from instruction_types.defs.
- REGISTER_WIDTH, 5, register index width.
- COUNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  field record valid.
- in_ready  output  1  encoder can accept a record this cycle.
- in_type  input  TYPE_WIDTH  format: `R_TYPE/`I_TYPE/`S_TYPE/`SB_TYPE/`U_TYPE/`UJ_TYPE/other.
- in_opcode  input  7  major opcode, bits [6:0].
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7 (R_TYPE only).
- in_rd, in_rs1, in_rs2  input  REGISTER_WIDTH  register indices.
- in_imm  input  IMMEDIATE_WIDTH  unscaled two's-complement byte offset/immediate.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer accepts the word.
- out_inst  output  32  encoded instruction.
- out_error  output  1  record was unencodable; out_inst = 32'h0000_0013 (NOP).
- enc_count  output  COUNT_WIDTH  words delivered without error, saturating.
- err_count  output  COUNT_WIDTH  words delivered with error, saturating.

Behaviour:
- Reset (async assert, sync release) clears:
  - out_valid=0, out_inst=0, out_error=0, enc_count=0, err_count=0.
  - in_ready=1 on the first cycle after release.
  - Stage valids cleared; any in-flight records are dropped, not delivered.
- Handshake:
  - Transfer when valid && ready on a rising edge.
  - out_valid, out_inst and out_error hold stable while out_valid && !out_ready.
  - in_ready does not depend combinationally on in_valid.
- Stage 1 (S1) registers the fields and computes range error and the format select.
- Stage 2 (S2) registers the packed word and error and drives the outputs.
- Advance rules:
  - S2 loads when !S2.valid || out_ready.
  - S1 advances when S2 loads.
  - in_ready = !S1.valid || S2 loads.
- Latency: the word is valid 2 cycles after input acceptance. Throughput is 1 per cycle with out_ready=1.
- Packing (imm is in_imm):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode. Error if imm[31:11] is not all-equal.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode. Same range rule as I.
  - SB: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode. Error if imm[31:12] is not all-equal or imm[0]=1.
  - U: imm[31:12] | rd | opcode. Error if imm[11:0] != 0.
  - UJ: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode. Error if imm[31:20] is not all-equal or imm[0]=1.
  - Any other type code: error.
- Error output: out_inst=32'h0000_0013, out_error=1. Unused input fields are ignored.
- Counters:
  - Increment on the output transfer (out_valid && out_ready): enc_count if !out_error, else err_count.
  - Saturate at all-ones; no wrap.
- Simultaneous accept and deliver in one cycle is legal; both occur and neither is lost.

Test Plan:
- ADD x3,x1,x2: R, op 0x33, f3 0, f7 0, rd 3, rs1 1, rs2 2 -> out_inst 0x002081B3, error 0, 2 cycles after accept, enc_count 1.
- ADDI x1,x0,-1 (I, op 0x13, imm 0xFFFFFFFF) -> 0xFFF00093. Then imm 2048 -> out_error 1, out_inst 0x00000013, err_count 1.
- BEQ x1,x2,+8 (SB, op 0x63) -> 0x00208463; imm 7 -> error. JAL x1,+2048 (UJ, op 0x6F) -> 0x001000EF. LUI x5,0x12345000 (U, op 0x37) -> 0x123452B7; imm 0x12345001 -> error.
- Backpressure: out_ready=0, offer 3 back-to-back records -> 2 accepted, in_ready=0 from the 3rd; out_inst stable. Release out_ready -> all 3 delivered in order, one per cycle, none duplicated.
- Saturation: force 0xFFFF+2 error-free deliveries (or COUNT_WIDTH=2 build) -> enc_count sticks at all-ones.
- Reset mid-stream with both stages full -> out_valid=0 and counters 0 immediately (asynchronous); no stale word appears after release.
